// File: rtl/tl_pkg.sv
// Shared state encoding and index helper for the traffic intersection controller.
package tl_pkg;

  localparam int TL_STATE_W = 2;

  typedef enum logic [TL_STATE_W-1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2,
    WALK    = 2'd3
  } tl_state_e;

  // (idx + off) mod n, valid for idx < n and off < n
  function automatic int unsigned tl_next_idx(input int unsigned idx,
                                              input int unsigned off,
                                              input int unsigned n);
    int unsigned sum;
    sum = idx + off;
    if (sum >= n) begin
      sum = sum - n;
    end else begin
      sum = sum + 32'd0;
    end
    return sum;
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// Sensor/timebase inputs and lamp outputs of the traffic intersection controller.
interface traffic_intersection_ctrl_if #(
  parameter int NUM_DIR = 4
);
  localparam int DIR_W = $clog2(NUM_DIR);

  logic               tick;
  logic [NUM_DIR-1:0] car_req;
  logic               ped_req;
  logic [NUM_DIR-1:0] green;
  logic [NUM_DIR-1:0] yellow;
  logic [NUM_DIR-1:0] red;
  logic [DIR_W-1:0]   active_dir;
  logic               walk;

  modport master (
    output tick, car_req, ped_req,
    input  green, yellow, red, active_dir, walk
  );

  modport slave (
    input  tick, car_req, ped_req,
    output green, yellow, red, active_dir, walk
  );
endinterface

// File: rtl/tl_rr_next.sv
// Round-robin picker: first requesting approach after active_dir, else active_dir+1.
module tl_rr_next
  import tl_pkg::*;
#(
  parameter int NUM_DIR = 4,
  parameter int DIR_W   = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] car_req,
  input  logic [DIR_W-1:0]   active_dir,
  output logic [DIR_W-1:0]   next_dir,
  output logic               any_other_req
);

  logic [DIR_W-1:0] idx_s;

  // scan farthest offset first so the nearest requester overwrites the result
  always_comb begin
    next_dir      = DIR_W'(tl_next_idx(32'(active_dir), 32'd1, NUM_DIR));
    any_other_req = 1'b0;
    idx_s         = {DIR_W{1'b0}};
    for (int unsigned k = NUM_DIR - 1; k >= 32'd1; k--) begin
      idx_s = DIR_W'(tl_next_idx(32'(active_dir), k, NUM_DIR));
      if (car_req[idx_s]) begin
        next_dir      = idx_s;
        any_other_req = 1'b1;
      end else begin
        any_other_req = any_other_req;
      end
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Moore traffic controller: GREEN -> YELLOW -> ALL_RED (-> WALK) with round-robin approach selection.
// Optional pedestrian phase enabled by defining TL_PED_EN.
module traffic_intersection_ctrl
  import tl_pkg::*;
#(
  parameter int NUM_DIR    = 4,
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 4,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 3
) (
  input logic clk,
  input logic rst_n,
  traffic_intersection_ctrl_if.slave bus
);

  localparam int DIR_W = $clog2(NUM_DIR);
  localparam logic [NUM_DIR-1:0] ONE_HOT0 = {{(NUM_DIR-1){1'b0}}, 1'b1};

  tl_state_e          state_r, state_nx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nx_s, dur_s;
  logic [DIR_W-1:0]   dir_r, dir_nx_s, next_dir_s;
  logic               any_other_s;
  logic               ped_pending_s;
  logic [NUM_DIR-1:0] green_r, yellow_r, red_r;
  logic [NUM_DIR-1:0] green_nx_s, yellow_nx_s;
  logic               walk_r, walk_nx_s;

  tl_rr_next #(.NUM_DIR(NUM_DIR), .DIR_W(DIR_W)) u_rr (
    .car_req       (bus.car_req),
    .active_dir    (dir_r),
    .next_dir      (next_dir_s),
    .any_other_req (any_other_s)
  );

`ifdef TL_PED_EN
  logic ped_pending_r;
  logic ped_clr_s;

  assign ped_clr_s     = (state_nx_s == WALK) && (state_r != WALK);
  assign ped_pending_s = ped_pending_r;

  // pending pedestrian request; entering WALK clears it even against a new press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending_r <= 1'b0;
    end else if (ped_clr_s) begin
      ped_pending_r <= 1'b0;
    end else if (bus.ped_req) begin
      ped_pending_r <= 1'b1;
    end else begin
      ped_pending_r <= ped_pending_r;
    end
  end
`else
  assign ped_pending_s = 1'b0;
`endif

  // last counter value of the current phase
  always_comb begin
    case (state_r)
      GREEN:   dur_s = CNT_W'(GREEN_CYC - 1);
      YELLOW:  dur_s = CNT_W'(YELLOW_CYC - 1);
      ALL_RED: dur_s = CNT_W'(ALLRED_CYC - 1);
      WALK:    dur_s = CNT_W'(WALK_CYC - 1);
      default: dur_s = {CNT_W{1'b0}};
    endcase
  end

  // next state; GREEN saturates its counter while nobody else waits
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    dir_nx_s   = dir_r;
    if (!bus.tick) begin
      cnt_nx_s = cnt_r;
    end else if (cnt_r != dur_s) begin
      cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      case (state_r)
        GREEN: begin
          if (any_other_s || ped_pending_s) begin
            state_nx_s = YELLOW;
            cnt_nx_s   = {CNT_W{1'b0}};
          end else begin
            cnt_nx_s = cnt_r;
          end
        end
        YELLOW: begin
          state_nx_s = ALL_RED;
          cnt_nx_s   = {CNT_W{1'b0}};
        end
        ALL_RED: begin
          cnt_nx_s = {CNT_W{1'b0}};
          if (ped_pending_s) begin
            state_nx_s = WALK;
          end else begin
            state_nx_s = GREEN;
            dir_nx_s   = next_dir_s;
          end
        end
        WALK: begin
          state_nx_s = GREEN;
          cnt_nx_s   = {CNT_W{1'b0}};
          dir_nx_s   = next_dir_s;
        end
        default: begin
          state_nx_s = GREEN;
          cnt_nx_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // lamps decoded from the next state so the registered lamps track the state register
  always_comb begin
    green_nx_s  = {NUM_DIR{1'b0}};
    yellow_nx_s = {NUM_DIR{1'b0}};
    walk_nx_s   = 1'b0;
    case (state_nx_s)
      GREEN:   green_nx_s  = ONE_HOT0 << dir_nx_s;
      YELLOW:  yellow_nx_s = ONE_HOT0 << dir_nx_s;
      WALK:    walk_nx_s   = 1'b1;
      default: walk_nx_s   = 1'b0;
    endcase
  end

  // state, counter, active approach and lamp registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= GREEN;
      cnt_r    <= {CNT_W{1'b0}};
      dir_r    <= {DIR_W{1'b0}};
      green_r  <= ONE_HOT0;
      yellow_r <= {NUM_DIR{1'b0}};
      red_r    <= ~ONE_HOT0;
      walk_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      dir_r    <= dir_nx_s;
      green_r  <= green_nx_s;
      yellow_r <= yellow_nx_s;
      red_r    <= ~(green_nx_s | yellow_nx_s);
      walk_r   <= walk_nx_s;
    end
  end

  assign bus.green      = green_r;
  assign bus.yellow     = yellow_r;
  assign bus.red        = red_r;
  assign bus.active_dir = dir_r;
  assign bus.walk       = walk_r;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed, table-driven bench for traffic_intersection_ctrl (default parameters).
module tb_traffic_intersection_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  traffic_intersection_ctrl_if #(.NUM_DIR(4)) bus ();

  traffic_intersection_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic [3:0] car;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic t, input logic [3:0] c, input logic [3:0] g,
                     input logic [3:0] y, input logic [1:0] d);
    vec_t v;
    v = '{t, c, g, y, d};
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [3:0] ey,
                       input logic [1:0] ed, input logic ew);
    logic [3:0] er;
    er = ~(eg | ey);
    n_checks++;
    if (bus.green !== eg || bus.yellow !== ey || bus.red !== er ||
        bus.active_dir !== ed || bus.walk !== ew) begin
      n_errors++;
      $display("FAIL %s: got g=%b y=%b r=%b dir=%0d walk=%b, want g=%b y=%b r=%b dir=%0d walk=%b",
               name, bus.green, bus.yellow, bus.red, bus.active_dir, bus.walk,
               eg, ey, er, ed, ew);
    end
  endtask

  task automatic do_reset();
    bus.tick    = 1'b1;
    bus.car_req = 4'b0000;
    bus.ped_req = 1'b0;
    rst_n       = 1'b0;
    step();
    check("reset", 4'b0001, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // rows: tick, car_req, expected green, yellow, active_dir after the edge
    add(1'b1, 4'b0100, 4'b0001, 4'b0000, 2'd0);
    add(1'b1, 4'b0100, 4'b0001, 4'b0000, 2'd0);
    add(1'b1, 4'b0100, 4'b0001, 4'b0000, 2'd0);
    add(1'b1, 4'b0100, 4'b0000, 4'b0001, 2'd0);
    add(1'b1, 4'b0100, 4'b0000, 4'b0001, 2'd0);
    add(1'b1, 4'b0100, 4'b0000, 4'b0000, 2'd0);
    add(1'b1, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    add(1'b1, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    add(1'b1, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    add(1'b1, 4'b0100, 4'b0100, 4'b0000, 2'd2);
    add(1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd2);
    add(1'b1, 4'b1001, 4'b0000, 4'b0100, 2'd2);
    add(1'b0, 4'b1001, 4'b0000, 4'b0100, 2'd2);
    add(1'b1, 4'b1001, 4'b0000, 4'b0100, 2'd2);
    add(1'b1, 4'b1001, 4'b0000, 4'b0000, 2'd2);
    add(1'b1, 4'b1001, 4'b1000, 4'b0000, 2'd3);
    add(1'b1, 4'b0000, 4'b1000, 4'b0000, 2'd3);
    add(1'b0, 4'b0001, 4'b1000, 4'b0000, 2'd3);
    add(1'b1, 4'b0000, 4'b1000, 4'b0000, 2'd3);
    add(1'b1, 4'b0000, 4'b1000, 4'b0000, 2'd3);
    add(1'b1, 4'b1000, 4'b1000, 4'b0000, 2'd3);
    add(1'b1, 4'b0001, 4'b0000, 4'b1000, 2'd3);
    add(1'b1, 4'b0000, 4'b0000, 4'b1000, 2'd3);
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd3);
    add(1'b1, 4'b0000, 4'b0001, 4'b0000, 2'd0);

    bus.tick    = 1'b1;
    bus.car_req = 4'b0000;
    bus.ped_req = 1'b0;
    #2;

    // table: rotation, hold, tick freeze, wrap-around priority, fallback to active+1
    do_reset();
    foreach (vecs[i]) begin
      bus.tick    = vecs[i].tick;
      bus.car_req = vecs[i].car;
      step();
      check($sformatf("vec%0d", i + 1), vecs[i].g, vecs[i].y, vecs[i].d, 1'b0);
    end

    // long hold with no requests, then a late request
    do_reset();
    for (int e = 1; e <= 100; e++) begin
      step();
      check($sformatf("hold%0d", e), 4'b0001, 4'b0000, 2'd0, 1'b0);
    end
    bus.car_req = 4'b1000;
    step(); check("late_y1", 4'b0000, 4'b0001, 2'd0, 1'b0);
    step(); check("late_y2", 4'b0000, 4'b0001, 2'd0, 1'b0);
    step(); check("late_ar", 4'b0000, 4'b0000, 2'd0, 1'b0);
    step(); check("late_g3", 4'b1000, 4'b0000, 2'd3, 1'b0);

    // tick one cycle in three
    do_reset();
    bus.car_req = 4'b0010;
    for (int e = 1; e <= 21; e++) begin
      bus.tick = (e % 3 == 0);
      step();
      if (e < 12)      check($sformatf("slow%0d", e), 4'b0001, 4'b0000, 2'd0, 1'b0);
      else if (e < 18) check($sformatf("slow%0d", e), 4'b0000, 4'b0001, 2'd0, 1'b0);
      else if (e < 21) check($sformatf("slow%0d", e), 4'b0000, 4'b0000, 2'd0, 1'b0);
      else             check($sformatf("slow%0d", e), 4'b0010, 4'b0000, 2'd1, 1'b0);
    end
    bus.tick = 1'b1;

`ifdef TL_PED_EN
    // pedestrian pulse, then confirm the request was consumed
    do_reset();
    bus.ped_req = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      bus.ped_req = 1'b0;
      if (e < 4)       check($sformatf("ped%0d", e), 4'b0001, 4'b0000, 2'd0, 1'b0);
      else if (e < 6)  check($sformatf("ped%0d", e), 4'b0000, 4'b0001, 2'd0, 1'b0);
      else if (e < 7)  check($sformatf("ped%0d", e), 4'b0000, 4'b0000, 2'd0, 1'b0);
      else if (e < 10) check($sformatf("ped%0d", e), 4'b0000, 4'b0000, 2'd0, 1'b1);
      else             check($sformatf("ped%0d", e), 4'b0010, 4'b0000, 2'd1, 1'b0);
    end
`endif

    // asynchronous reset during yellow on approach 2
    do_reset();
    bus.car_req = 4'b0100;
    for (int e = 1; e <= 7; e++) step();
    check("pre_g2", 4'b0100, 4'b0000, 2'd2, 1'b0);
    bus.car_req = 4'b0001;
    for (int e = 8; e <= 11; e++) step();
    check("pre_y2", 4'b0000, 4'b0100, 2'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst", 4'b0001, 4'b0000, 2'd0, 1'b0);
    n_checks++;
    if (dut.cnt_r !== 8'd0) begin
      n_errors++;
      $display("FAIL mid_rst_cnt: got %0d, want 0", dut.cnt_r);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    bus.car_req = 4'b0010;
    for (int e = 1; e <= 4; e++) begin
      step();
      if (e < 4) check($sformatf("post_rst%0d", e), 4'b0001, 4'b0000, 2'd0, 1'b0);
      else       check("post_rst_y", 4'b0000, 4'b0001, 2'd0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
